id_ex_reg: RTL and testbench
============================

Name: id_ex_reg

Overview:
- ID/EX pipeline register for the rv32i 5-stage core.
- Captures decode-stage operands and decoded control, including the ALU operation from the ALU decoder, on each rising clock edge.
- Presents them to the execute stage (ALU, branch compare, forwarding muxes).
- Supports stall (hold), flush (bubble insertion) and a saturating bubble counter for performance debug.

Parameters:
- XLEN, 32, datapath width for PC, register operands and immediate.
- CNT_W, 32, width of the bubble counter.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- stall_e  input  1  hold all E-stage contents this cycle.
- flush_e  input  1  load a bubble this cycle; source is a taken branch, a jump, or a load-use hazard.
- valid_d  input  1  decode stage holds a real instruction.
- pc_d, pc_plus4_d  input  XLEN  instruction PC and PC+4.
- rs1_data_d, rs2_data_d  input  XLEN  register file read data.
- imm_ext_d  input  XLEN  sign-extended immediate.
- rs1_addr_d, rs2_addr_d, rd_addr_d  input  5  register indices, used for forwarding and hazard detection.
- alu_ctrl_d  input  riscv_pkg::alu_op_e  ALU operation from the ALU decoder.
- alu_src_d  input  1  0 selects rs2, 1 selects imm.
- result_src_d  input  2  00 ALU, 01 memory, 10 PC+4.
- reg_write_d, mem_write_d, branch_d, jump_d  input  1  control bits.
- Outputs: one registered `*_e` output for each `*_d` input above, plus valid_e; same widths and meanings.
- bubble_cnt  output  CNT_W  number of bubbles inserted since reset.

Behaviour:
- Latency: exactly one cycle from `*_d` to `*_e` when neither stall_e nor flush_e is asserted.
- Reset (async, rst=1): all `*_e` outputs are driven to 0 immediately, and alu_ctrl_e is driven to ALU_ADD.
  - "All `*_e` outputs" includes valid_e, reg_write_e, mem_write_e, branch_e, jump_e, result_src_e, alu_src_e, all data and address fields, and bubble_cnt.
  - Outputs remain at these values while rst=1.
  - Release of rst takes effect at the first clock edge after deassertion.
  - A reset asserted mid-stall or mid-flush overrides everything.
- Per-edge priority: rst > flush_e > stall_e > normal load.
- flush_e=1 (also wins when stall_e=1 in the same cycle; a redirect kills the held instruction):
  - valid_e, reg_write_e, mem_write_e, branch_e and jump_e are cleared.
  - result_src_e is set to 00, alu_src_e to 0, and alu_ctrl_e to ALU_ADD.
  - All data and address fields are cleared to 0, so rd_addr_e=0 and forwarding can never match.
- stall_e=1, flush_e=0: every `*_e` output, including valid_e, holds its previous value. `*_d` inputs are ignored.
- Normal load: every `*_e` output takes the corresponding `*_d` value.
  - valid_e takes valid_d.
  - When valid_d=0, the control bits are still loaded as presented. Upstream guarantees they are zero for invalid instructions; this block does not mask them.
- Bubble counter:
  - Increments by 1 on each edge where flush_e=1 and rst=0, regardless of stall_e.
  - Saturates at 2^CNT_W-1 and never wraps.
  - It is not affected by stall.
- No combinational path from any input to any output.
- alu_ctrl_e is always a legal enum member; unknown values are never produced.

Test Plan:
- Reset mid-operation:
  - Load pc_d=0x0000_0040, alu_ctrl_d=ALU_SUB, reg_write_d=1 and clock once.
  - Assert rst asynchronously between edges.
  - Required: pc_e=0, reg_write_e=0, alu_ctrl_e=ALU_ADD and bubble_cnt=0 immediately, without waiting for an edge.
- Pass-through:
  - Back-to-back instructions `add x3,x1,x2` (alu_ctrl=ALU_ADD, rd=3) then `sub x4,x1,x2` (ALU_SUB, rd=4).
  - Required: each appears on the `*_e` outputs one cycle later, in order, with valid_e=1.
- Stall hold:
  - Load `slt` with rd=5, then assert stall_e for 3 cycles while `*_d` changes every cycle.
  - Required: rd_addr_e=5 and alu_ctrl_e=ALU_SLT for all 3 cycles; the new instruction appears the cycle after stall_e drops.
- Flush bubble:
  - Load `sw` (mem_write=1), then assert flush_e for 1 cycle.
  - Required: mem_write_e=0, valid_e=0, rd_addr_e=0, alu_ctrl_e=ALU_ADD and bubble_cnt=1.
- Simultaneous stall and flush:
  - Hold an instruction with rd=7, then assert stall_e=1 and flush_e=1 together.
  - Required: a bubble is produced (valid_e=0, rd_addr_e=0) and bubble_cnt increments.
- Counter saturation:
  - With CNT_W=4, assert flush_e for 20 consecutive cycles.
  - Required: bubble_cnt reaches 15 and stays at 15 with no wrap to 0.

Source files
------------

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: decode operands and control into execute.
// Ports: *_d in, *_e out, stall_e/flush_e, saturating bubble_cnt.
package riscv_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;

endpackage

module id_ex_reg
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_e,
  input  logic            flush_e,
  input  logic            valid_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic [XLEN-1:0] pc_plus4_d,
  input  logic [XLEN-1:0] rs1_data_d,
  input  logic [XLEN-1:0] rs2_data_d,
  input  logic [XLEN-1:0] imm_ext_d,
  input  logic [4:0]      rs1_addr_d,
  input  logic [4:0]      rs2_addr_d,
  input  logic [4:0]      rd_addr_d,
  input  alu_op_e         alu_ctrl_d,
  input  logic            alu_src_d,
  input  logic [1:0]      result_src_d,
  input  logic            reg_write_d,
  input  logic            mem_write_d,
  input  logic            branch_d,
  input  logic            jump_d,
  output logic            valid_e,
  output logic [XLEN-1:0] pc_e,
  output logic [XLEN-1:0] pc_plus4_e,
  output logic [XLEN-1:0] rs1_data_e,
  output logic [XLEN-1:0] rs2_data_e,
  output logic [XLEN-1:0] imm_ext_e,
  output logic [4:0]      rs1_addr_e,
  output logic [4:0]      rs2_addr_e,
  output logic [4:0]      rd_addr_e,
  output alu_op_e         alu_ctrl_e,
  output logic            alu_src_e,
  output logic [1:0]      result_src_e,
  output logic            reg_write_e,
  output logic            mem_write_e,
  output logic            branch_e,
  output logic            jump_e,
  output logic [CNT_W-1:0] bubble_cnt
);

  // A bubble zeroes every field, so rd_addr_e=0 never matches a
  // forwarding source; reset and flush share this value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_e      <= 1'b0;
      pc_e         <= '0;
      pc_plus4_e   <= '0;
      rs1_data_e   <= '0;
      rs2_data_e   <= '0;
      imm_ext_e    <= '0;
      rs1_addr_e   <= '0;
      rs2_addr_e   <= '0;
      rd_addr_e    <= '0;
      alu_ctrl_e   <= ALU_ADD;
      alu_src_e    <= 1'b0;
      result_src_e <= 2'b00;
      reg_write_e  <= 1'b0;
      mem_write_e  <= 1'b0;
      branch_e     <= 1'b0;
      jump_e       <= 1'b0;
      bubble_cnt   <= '0;
    end else if (flush_e) begin
      valid_e      <= 1'b0;
      pc_e         <= '0;
      pc_plus4_e   <= '0;
      rs1_data_e   <= '0;
      rs2_data_e   <= '0;
      imm_ext_e    <= '0;
      rs1_addr_e   <= '0;
      rs2_addr_e   <= '0;
      rd_addr_e    <= '0;
      alu_ctrl_e   <= ALU_ADD;
      alu_src_e    <= 1'b0;
      result_src_e <= 2'b00;
      reg_write_e  <= 1'b0;
      mem_write_e  <= 1'b0;
      branch_e     <= 1'b0;
      jump_e       <= 1'b0;
      // Saturate rather than wrap so a long run stays readable.
      if (bubble_cnt != {CNT_W{1'b1}})
        bubble_cnt <= bubble_cnt + 1'b1;
    end else if (!stall_e) begin
      valid_e      <= valid_d;
      pc_e         <= pc_d;
      pc_plus4_e   <= pc_plus4_d;
      rs1_data_e   <= rs1_data_d;
      rs2_data_e   <= rs2_data_d;
      imm_ext_e    <= imm_ext_d;
      rs1_addr_e   <= rs1_addr_d;
      rs2_addr_e   <= rs2_addr_d;
      rd_addr_e    <= rd_addr_d;
      alu_ctrl_e   <= alu_ctrl_d;
      alu_src_e    <= alu_src_d;
      result_src_e <= result_src_d;
      reg_write_e  <= reg_write_d;
      mem_write_e  <= mem_write_d;
      branch_e     <= branch_d;
      jump_e       <= jump_d;
    end
  end

endmodule

// File: tb/tb_id_ex_reg.sv
// Bench for id_ex_reg: directed scenarios then random traffic
// against a transaction-level model of the E-stage contents.
module tb_id_ex_reg;
  import riscv_pkg::*;

  localparam int CW = 4;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [4:0]  rs1a;
    logic [4:0]  rs2a;
    logic [4:0]  rda;
    alu_op_e     alu;
    logic        asrc;
    logic [1:0]  rsrc;
    logic        rw;
    logic        mw;
    logic        br;
    logic        jp;
  } st_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall = 1'b0;
  logic flush = 1'b0;
  st_t  d;

  logic        valid_e, alu_src_e, reg_write_e;
  logic        mem_write_e, branch_e, jump_e;
  logic [31:0] pc_e, pc_plus4_e, rs1_data_e;
  logic [31:0] rs2_data_e, imm_ext_e;
  logic [4:0]  rs1_addr_e, rs2_addr_e, rd_addr_e;
  alu_op_e     alu_ctrl_e;
  logic [1:0]  result_src_e;
  logic [CW-1:0] bubble_cnt;

  st_t exp_s;
  int  exp_cnt;
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  id_ex_reg #(.XLEN(32), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .stall_e(stall), .flush_e(flush),
    .valid_d(d.valid), .pc_d(d.pc),
    .pc_plus4_d(d.pc4),
    .rs1_data_d(d.rs1d), .rs2_data_d(d.rs2d),
    .imm_ext_d(d.imm),
    .rs1_addr_d(d.rs1a), .rs2_addr_d(d.rs2a),
    .rd_addr_d(d.rda), .alu_ctrl_d(d.alu),
    .alu_src_d(d.asrc), .result_src_d(d.rsrc),
    .reg_write_d(d.rw), .mem_write_d(d.mw),
    .branch_d(d.br), .jump_d(d.jp),
    .valid_e(valid_e), .pc_e(pc_e),
    .pc_plus4_e(pc_plus4_e),
    .rs1_data_e(rs1_data_e), .rs2_data_e(rs2_data_e),
    .imm_ext_e(imm_ext_e),
    .rs1_addr_e(rs1_addr_e), .rs2_addr_e(rs2_addr_e),
    .rd_addr_e(rd_addr_e), .alu_ctrl_e(alu_ctrl_e),
    .alu_src_e(alu_src_e), .result_src_e(result_src_e),
    .reg_write_e(reg_write_e), .mem_write_e(mem_write_e),
    .branch_e(branch_e), .jump_e(jump_e),
    .bubble_cnt(bubble_cnt)
  );

  function automatic st_t bubble();
    st_t b;
    b = '0;
    b.alu = ALU_ADD;
    return b;
  endfunction

  function automatic st_t obs();
    st_t o;
    o.valid = valid_e;      o.pc   = pc_e;
    o.pc4   = pc_plus4_e;   o.rs1d = rs1_data_e;
    o.rs2d  = rs2_data_e;   o.imm  = imm_ext_e;
    o.rs1a  = rs1_addr_e;   o.rs2a = rs2_addr_e;
    o.rda   = rd_addr_e;    o.alu  = alu_ctrl_e;
    o.asrc  = alu_src_e;    o.rsrc = result_src_e;
    o.rw    = reg_write_e;  o.mw   = mem_write_e;
    o.br    = branch_e;     o.jp   = jump_e;
    return o;
  endfunction

  task automatic chk(string tag, logic [255:0] o,
                     logic [255:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, o, e);
    end
  endtask

  task automatic chk_all(string tag);
    chk({tag, ".fields"}, 256'(obs()), 256'(exp_s));
    chk({tag, ".cnt"}, 256'(bubble_cnt), 256'(exp_cnt));
  endtask

  // Model: what the E stage should hold after this edge.
  task automatic model_edge();
    if (rst) begin
      exp_s = bubble();
      exp_cnt = 0;
    end else if (flush) begin
      exp_s = bubble();
      exp_cnt = (exp_cnt < (1 << CW) - 1) ? exp_cnt + 1
                                          : exp_cnt;
    end else if (!stall) begin
      exp_s = d;
    end
  endtask

  task automatic step(string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk_all(tag);
  endtask

  task automatic rnd_in();
    d.valid = 1'($urandom);
    d.pc    = $urandom;
    d.pc4   = d.pc + 32'd4;
    d.rs1d  = $urandom;
    d.rs2d  = $urandom;
    d.imm   = $urandom;
    d.rs1a  = 5'($urandom);
    d.rs2a  = 5'($urandom);
    d.rda   = 5'($urandom);
    d.alu   = alu_op_e'($urandom_range(0, 9));
    d.asrc  = 1'($urandom);
    d.rsrc  = 2'($urandom_range(0, 2));
    d.rw    = 1'($urandom);
    d.mw    = 1'($urandom);
    d.br    = 1'($urandom);
    d.jp    = 1'($urandom);
  endtask

  task automatic instr(alu_op_e op, logic [4:0] rd,
                       logic [31:0] pc);
    rnd_in();
    d.valid = 1'b1;
    d.pc    = pc;
    d.pc4   = pc + 32'd4;
    d.alu   = op;
    d.rda   = rd;
    d.rs1a  = 5'd1;
    d.rs2a  = 5'd2;
    d.rw    = 1'b1;
    d.mw    = 1'b0;
    d.br    = 1'b0;
    d.jp    = 1'b0;
  endtask

  initial begin
    exp_s = bubble();
    exp_cnt = 0;
    rnd_in();
    #1;
    chk_all("reset_init");
    step("reset_hold");
    #2 rst = 1'b0;

    // Reset mid-operation, checked before any edge.
    instr(ALU_SUB, 5'd9, 32'h0000_0040);
    step("load_sub");
    chk("load_pc", 256'(pc_e), 256'h40);
    #2 rst = 1'b1;
    #1;
    exp_s = bubble();
    exp_cnt = 0;
    chk_all("async_rst");
    chk("async_alu", 256'(alu_ctrl_e), 256'(ALU_ADD));
    step("rst_edge");
    #2 rst = 1'b0;

    // Pass-through add then sub.
    instr(ALU_ADD, 5'd3, 32'h100);
    step("add_e");
    chk("add_rd", 256'(rd_addr_e), 256'd3);
    instr(ALU_SUB, 5'd4, 32'h104);
    step("sub_e");
    chk("sub_rd", 256'(rd_addr_e), 256'd4);
    chk("sub_valid", 256'(valid_e), 256'd1);

    // Stall hold.
    instr(ALU_SLT, 5'd5, 32'h108);
    step("slt_e");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rnd_in();
      step("stall");
      chk("stall_rd", 256'(rd_addr_e), 256'd5);
      chk("stall_alu", 256'(alu_ctrl_e), 256'(ALU_SLT));
    end
    stall = 1'b0;
    instr(ALU_OR, 5'd6, 32'h10c);
    step("after_stall");
    chk("after_stall_rd", 256'(rd_addr_e), 256'd6);

    // Flush a store.
    instr(ALU_ADD, 5'd0, 32'h110);
    d.mw = 1'b1;
    d.rw = 1'b0;
    step("sw_e");
    chk("sw_mw", 256'(mem_write_e), 256'd1);
    flush = 1'b1;
    rnd_in();
    step("flush");
    chk("flush_mw", 256'(mem_write_e), 256'd0);
    chk("flush_rd", 256'(rd_addr_e), 256'd0);
    chk("flush_cnt", 256'(bubble_cnt), 256'd1);
    flush = 1'b0;

    // Stall and flush together.
    instr(ALU_XOR, 5'd7, 32'h114);
    step("rd7_e");
    stall = 1'b1;
    rnd_in();
    step("rd7_hold");
    chk("rd7_held", 256'(rd_addr_e), 256'd7);
    flush = 1'b1;
    step("stall_flush");
    chk("sf_valid", 256'(valid_e), 256'd0);
    chk("sf_rd", 256'(rd_addr_e), 256'd0);
    chk("sf_cnt", 256'(bubble_cnt), 256'd2);
    stall = 1'b0;

    // Saturation.
    for (int i = 0; i < 20; i++) begin
      rnd_in();
      step("sat");
    end
    chk("sat_cnt", 256'(bubble_cnt), 256'd15);
    flush = 1'b0;

    // Reset clears a saturated counter.
    #2 rst = 1'b1;
    #1;
    exp_s = bubble();
    exp_cnt = 0;
    chk_all("rst_sat");
    step("rst_sat_edge");
    #2 rst = 1'b0;

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      rnd_in();
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
